gate_vector_sequencer: RTL

//   Self-checking stimulus controller for a 2-input combinational gate under test.
//   On start, drives the gate's x/y inputs through all four input combinations.

---
 rtl/gate_vector_sequencer_pkg.sv | 16 +
 rtl/gate_vector_sequencer_if.sv | 25 ++
 rtl/gate_vector_sequencer_dwell_timer.sv | 32 +++
 rtl/gate_vector_sequencer.sv | 119 +++++++++++
 4 files changed

// File: rtl/gate_vector_sequencer_pkg.sv
// Shared types and widths for the gate vector sequencer.
package gate_vector_sequencer_pkg;

  localparam int unsigned VEC_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef logic [VEC_W-1:0] vec_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/gate_vector_sequencer_if.sv
// Control/status bundle between the experiment top level and the sequencer.
interface gate_vector_sequencer_if;
  import gate_vector_sequencer_pkg::*;

  logic       start;
  logic       abort;
  logic       z;
  logic       x;
  logic       y;
  vec_t       vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_mask;

  modport master (
    output start, abort, z,
    input  x, y, vec_idx, busy, done, pass, err_mask
  );

  modport slave (
    input  start, abort, z,
    output x, y, vec_idx, busy, done, pass, err_mask
  );
endinterface

// File: rtl/gate_vector_sequencer_dwell_timer.sv
// Per-vector dwell counter; flags the sample offset and the last cycle of a vector.
module dwell_timer
  import gate_vector_sequencer_pkg::*;
#(
  parameter int unsigned DWELL  = 20,
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic at_settle_o,
  output logic at_last_o
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + cnt_t'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign at_settle_o = (cnt_q == cnt_t'(SETTLE));
  assign at_last_o   = (cnt_q == cnt_t'(DWELL - 1));

endmodule

// File: rtl/gate_vector_sequencer.sv
// Walks a 2-input gate through all four input vectors and checks z against a truth table.
module gate_vector_sequencer
  import gate_vector_sequencer_pkg::*;
#(
  parameter int unsigned DWELL        = 20,
  parameter int unsigned SETTLE       = 1,
  parameter logic [3:0]  EXPECT       = 4'b1000,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gate_vector_sequencer_if.slave bus
);

  state_e     state_q, state_d;
  vec_t       vec_q, vec_d;
  logic [3:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       x_q, x_d, y_q, y_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tmr_clr, tmr_en, at_settle, at_last;
  logic       miss, finish;

  dwell_timer #(.DWELL(DWELL), .SETTLE(SETTLE)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (tmr_clr),
    .en_i       (tmr_en),
    .at_settle_o(at_settle),
    .at_last_o  (at_last)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    pass_d  = pass_q;
    x_d     = 1'b0;
    y_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    finish  = 1'b0;
    miss    = bus.z ^ EXPECT[vec_q];
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_APPLY;
          vec_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          tmr_clr = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_APPLY: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          tmr_en       = 1'b1;
          busy_d       = 1'b1;
          {x_d, y_d}   = vec_q;
          if (at_settle) err_d[vec_q] = miss;
          // Early stop fires on the sampling edge itself, so DONE follows the sample directly.
          if ((at_settle && miss && STOP_ON_FAIL) || (at_last && vec_q == '1)) begin
            finish = 1'b1;
          end else if (at_last) begin
            vec_d      = vec_q + vec_t'(1);
            {x_d, y_d} = vec_q + vec_t'(1);
            tmr_clr    = 1'b1;
          end
          if (finish) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            x_d     = 1'b0;
            y_d     = 1'b0;
            done_d  = 1'b1;
            pass_d  = ~|err_d;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.vec_idx  = vec_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_mask = err_q;

endmodule
